// File: rtl/arch_check_pkg.sv
// ============================================================================
//  arch_check_pkg
//  Shared state encoding and fail codes for the store-stream checker.
//  Rev 1.0
// ============================================================================
`default_nettype none

package arch_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_BAD_ADDR = 2'd1;
    localparam logic [1:0] FC_BAD_DATA = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mem_write_checker_if.sv
// ============================================================================
//  mem_write_checker_if
//  Data-memory store port as seen between the processor top and the checker.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface mem_write_checker_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    modport master (output memwrite, output dataadr, output writedata);
    modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

`default_nettype wire

// File: rtl/store_hist_ring.sv
// ============================================================================
//  store_hist_ring
//  Four-entry {addr, data} ring of recent stores with newest-relative readout.
//  Rev 1.0
// ============================================================================
`default_nettype none

module store_hist_ring (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        wr_en,
    input  wire logic [31:0] wr_addr,
    input  wire logic [31:0] wr_data,
    input  wire logic [1:0]  rd_idx,
    output logic      [31:0] rd_addr,
    output logic      [31:0] rd_data,
    output logic             rd_valid
);

    logic [3:0][31:0] r_addr;
    logic [3:0][31:0] r_data;
    logic [3:0]       r_valid;
    logic [1:0]       r_wptr;
    logic [1:0]       w_rd_slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_wptr  <= 2'd0;
        end else if (wr_en) begin
            r_addr[r_wptr]  <= wr_addr;
            r_data[r_wptr]  <= wr_data;
            r_valid[r_wptr] <= 1'b1;
            r_wptr          <= r_wptr + 2'd1;
        end
    end

    // 2-bit arithmetic gives the mod-4 wrap: idx 0 is the slot just written.
    assign w_rd_slot = r_wptr - 2'd1 - rd_idx;
    assign rd_valid  = r_valid[w_rd_slot];
    assign rd_addr   = rd_valid ? r_addr[w_rd_slot] : 32'd0;
    assign rd_data   = rd_valid ? r_data[w_rd_slot] : 32'd0;

endmodule

`default_nettype wire

// File: rtl/mem_write_checker.sv
// ============================================================================
//  mem_write_checker
//  Watches committed stores and renders a sticky on-chip pass/fail verdict.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_write_checker
    import arch_check_pkg::*;
#(
    parameter logic [31:0] TARGET_ADDR    = 32'd84,
    parameter logic [31:0] TARGET_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mem_write_checker_if.slave    bus,
    input  wire logic [1:0]       hist_idx,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic      [1:0]       fail_code,
    output logic      [CNT_W-1:0] write_count,
    output logic      [CNT_W-1:0] cycle_count,
    output logic      [31:0]      hist_addr,
    output logic      [31:0]      hist_data,
    output logic                  hist_valid
);

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

    state_t           r_state;
    logic             w_store;
    logic [CNT_W-1:0] w_cycle_next;
    logic [CNT_W-1:0] w_write_next;

    assign w_store      = (r_state == RUN) && bus.memwrite;
    assign w_cycle_next = (cycle_count == '1) ? cycle_count : cycle_count + c_one;
    assign w_write_next = (write_count == '1) ? write_count : write_count + c_one;

    // A store decision always takes priority over the timeout on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FC_NONE;
            write_count <= '0;
            cycle_count <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= RUN;
                RUN: begin
                    cycle_count <= w_cycle_next;
                    if (bus.memwrite) begin
                        write_count <= w_write_next;
                        if (bus.dataadr == TARGET_ADDR) begin
                            done <= 1'b1;
                            if (bus.writedata == TARGET_DATA) begin
                                r_state <= PASS;
                                pass    <= 1'b1;
                            end else begin
                                r_state   <= FAIL;
                                fail      <= 1'b1;
                                fail_code <= FC_BAD_DATA;
                            end
                        end else if (bus.dataadr != SCRATCH_ADDR) begin
                            r_state   <= FAIL;
                            done      <= 1'b1;
                            fail      <= 1'b1;
                            fail_code <= FC_BAD_ADDR;
                        end
                    end else if (cycle_count == c_timeout_last) begin
                        r_state   <= FAIL;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    store_hist_ring u_hist (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_store),
        .wr_addr  (bus.dataadr),
        .wr_data  (bus.writedata),
        .rd_idx   (hist_idx),
        .rd_addr  (hist_addr),
        .rd_data  (hist_data),
        .rd_valid (hist_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// ============================================================================
//  tb_mem_write_checker
//  Directed-vector bench for mem_write_checker with hand-computed expectations.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_write_checker;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [1:0]       hist_idx;
    logic             done;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] write_count;
    logic [CNT_W-1:0] cycle_count;
    logic [31:0]      hist_addr;
    logic [31:0]      hist_data;
    logic             hist_valid;

    int n_checks = 0;
    int n_errors = 0;

    mem_write_checker_if bus_if ();

    mem_write_checker #(
        .TARGET_ADDR    (32'd84),
        .TARGET_DATA    (32'd7),
        .SCRATCH_ADDR   (32'd80),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .hist_idx    (hist_idx),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .fail_code   (fail_code),
        .write_count (write_count),
        .cycle_count (cycle_count),
        .hist_addr   (hist_addr),
        .hist_data   (hist_data),
        .hist_valid  (hist_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; the store commits on the following posedge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.memwrite  = 1'b1;
        bus_if.dataadr   = a;
        bus_if.writedata = d;
        @(negedge clk);
        bus_if.memwrite  = 1'b0;
    endtask

    // Returns at the negedge after the IDLE->RUN edge.
    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic hist_check(input string tag, input logic [1:0] idx, input logic v,
                              input logic [31:0] a, input logic [31:0] d);
        hist_idx = idx;
        #1;
        check({tag, "_valid"}, {31'd0, hist_valid}, {31'd0, v});
        check({tag, "_addr"}, hist_addr, a);
        check({tag, "_data"}, hist_data, d);
    endtask

    // Three stores ending in the target value; shared by the first and post-abort runs.
    task automatic basic_run(input string tag);
        store(32'd80, 32'd3);
        store(32'd80, 32'd5);
        store(32'd84, 32'd7);
        check({tag, "_pass"}, {31'd0, pass}, 32'd1);
        check({tag, "_fail"}, {31'd0, fail}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_code"}, {30'd0, fail_code}, 32'd0);
        check({tag, "_wcnt"}, {16'd0, write_count}, 32'd3);
        check({tag, "_ccnt"}, {16'd0, cycle_count}, 32'd3);
        hist_check({tag, "_h0"}, 2'd0, 1'b1, 32'd84, 32'd7);
        hist_check({tag, "_h1"}, 2'd1, 1'b1, 32'd80, 32'd5);
        hist_check({tag, "_h2"}, 2'd2, 1'b1, 32'd80, 32'd3);
        hist_check({tag, "_h3"}, 2'd3, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        hist_idx         = 2'd0;
        bus_if.memwrite  = 1'b0;
        bus_if.dataadr   = 32'd0;
        bus_if.writedata = 32'd0;

        #10;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_fail", {31'd0, fail}, 32'd0);
        check("rst_code", {30'd0, fail_code}, 32'd0);
        check("rst_wcnt", {16'd0, write_count}, 32'd0);
        check("rst_ccnt", {16'd0, cycle_count}, 32'd0);
        check("rst_hvalid", {31'd0, hist_valid}, 32'd0);
        check("rst_haddr", hist_addr, 32'd0);
        #12 reset = 1'b0;
        @(negedge clk);

        basic_run("s1");
        @(negedge clk);
        store(32'd80, 32'd9);
        check("s1_absorb_wcnt", {16'd0, write_count}, 32'd3);
        check("s1_absorb_pass", {31'd0, pass}, 32'd1);
        hist_check("s1_absorb_h0", 2'd0, 1'b1, 32'd84, 32'd7);

        restart();
        store(32'd84, 32'd6);
        check("s2_fail", {31'd0, fail}, 32'd1);
        check("s2_code", {30'd0, fail_code}, 32'd2);
        check("s2_done", {31'd0, done}, 32'd1);
        store(32'd84, 32'd7);
        check("s2_late_pass", {31'd0, pass}, 32'd0);
        check("s2_late_wcnt", {16'd0, write_count}, 32'd1);
        check("s2_late_code", {30'd0, fail_code}, 32'd2);

        restart();
        store(32'd88, 32'd7);
        check("s3_fail", {31'd0, fail}, 32'd1);
        check("s3_code", {30'd0, fail_code}, 32'd1);
        check("s3_pass", {31'd0, pass}, 32'd0);

        restart();
        repeat (19) @(negedge clk);
        check("s4_pre_fail", {31'd0, fail}, 32'd0);
        check("s4_pre_ccnt", {16'd0, cycle_count}, 32'd19);
        @(negedge clk);
        check("s4_fail", {31'd0, fail}, 32'd1);
        check("s4_code", {30'd0, fail_code}, 32'd3);
        check("s4_ccnt", {16'd0, cycle_count}, 32'd20);
        repeat (3) @(negedge clk);
        check("s4_ccnt_frozen", {16'd0, cycle_count}, 32'd20);

        restart();
        repeat (19) @(negedge clk);
        store(32'd84, 32'd7);
        check("s4b_pass", {31'd0, pass}, 32'd1);
        check("s4b_fail", {31'd0, fail}, 32'd0);
        check("s4b_code", {30'd0, fail_code}, 32'd0);
        check("s4b_ccnt", {16'd0, cycle_count}, 32'd20);

        restart();
        for (int i = 1; i <= 6; i++) store(32'd80, 32'(i));
        store(32'd84, 32'd7);
        check("s5_pass", {31'd0, pass}, 32'd1);
        check("s5_wcnt", {16'd0, write_count}, 32'd7);
        hist_check("s5_h0", 2'd0, 1'b1, 32'd84, 32'd7);
        hist_check("s5_h1", 2'd1, 1'b1, 32'd80, 32'd6);
        hist_check("s5_h2", 2'd2, 1'b1, 32'd80, 32'd5);
        hist_check("s5_h3", 2'd3, 1'b1, 32'd80, 32'd4);

        restart();
        store(32'd80, 32'd3);
        store(32'd80, 32'd5);
        check("s6_pre_wcnt", {16'd0, write_count}, 32'd2);
        hist_idx = 2'd0;
        #1 reset = 1'b1;
        #1;
        check("s6_rst_wcnt", {16'd0, write_count}, 32'd0);
        check("s6_rst_ccnt", {16'd0, cycle_count}, 32'd0);
        check("s6_rst_done", {31'd0, done}, 32'd0);
        check("s6_rst_hvalid", {31'd0, hist_valid}, 32'd0);
        check("s6_rst_haddr", hist_addr, 32'd0);
        check("s6_rst_hdata", hist_data, 32'd0);
        #2 reset = 1'b0;
        @(negedge clk);
        basic_run("s6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
